// File: rtl/uart_rx_frame_ctl_pkg.sv
// Shared frame definitions for the UART receive frame controller:
// sync byte, sequencer state encoding and the error pulse bundle.
package uart_rx_frame_ctl_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PLD  = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } frame_state_e;

  typedef struct packed {
    logic chk;
    logic len;
    logic tmo;
    logic frm;
    logic ovr;
  } frame_err_t;

  localparam frame_err_t ERR_NONE = '0;

  // States in which a frame is being collected and the inter-byte timer runs.
  function automatic logic in_frame(frame_state_e s);
    return (s == ST_CMD) || (s == ST_LEN) || (s == ST_PLD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_frame_tmo.sv
// Inter-byte timeout counter. Counts while run=1, restarts on clr or when
// idle, and flags expired on the last count so the caller can act on it.
module uart_frame_tmo
  import uart_rx_frame_ctl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic clk_rx,
  input  logic rst_clk_rx,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expired = run && (count == CNT_LAST);

  // Counter restarts on every byte, whenever no frame is open, and after expiry.
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      count <= '0;
    end else if (clr || !run || expired) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctl.sv
// UART receive frame controller: assembles SYNC/CMD/LEN/payload/CHK frames
// from the byte stream, buffers the payload and holds one validated command
// until the consumer takes it. Errors are reported as one-cycle pulses.
//
// state | meaning
// HUNT  | waiting for the sync byte
// CMD   | next byte is the command code
// LEN   | next byte is the payload length
// PLD   | collecting payload bytes
// CHK   | next byte is the XOR checksum
// HOLD  | validated command presented on cmd_valid
module uart_rx_frame_ctl
  import uart_rx_frame_ctl_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int LEN_W          = 5,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic             clk_rx,
  input  logic             rst_clk_rx,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_rdy,
  input  logic             frm_err,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_code,
  output logic [LEN_W-1:0] cmd_len,
  input  logic [LEN_W-1:0] pld_addr,
  output logic [7:0]       pld_data,
  output logic             err_chk,
  output logic             err_len,
  output logic             err_tmo,
  output logic             err_frm,
  output logic             err_ovr
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  frame_state_e     state, state_nxt;
  frame_err_t       err_q, err_nxt;
  logic [7:0]       code_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [7:0]       chk_q;
  logic [7:0]       pld_buf [0:MAX_LEN-1];

  logic rx_ok;
  logic tmo_run;
  logic tmo_expired;
  logic ld_code;
  logic ld_len;
  logic wr_pld;

  assign rx_ok   = rx_data_rdy && !frm_err;
  assign tmo_run = in_frame(state);

  uart_frame_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_rx    (clk_rx),
    .rst_clk_rx(rst_clk_rx),
    .clr       (rx_data_rdy),
    .run       (tmo_run),
    .expired   (tmo_expired)
  );

  // State register.
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      state <= ST_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, error pulse selection and datapath load strobes.
  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_NONE;
    ld_code   = 1'b0;
    ld_len    = 1'b0;
    wr_pld    = 1'b0;
    unique case (state)
      ST_HUNT: begin
        if (rx_ok && (rx_data == SYNC_BYTE)) begin
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (rx_ok) begin
          ld_code   = 1'b1;
          state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_ok) begin
          if (rx_data > 8'(MAX_LEN)) begin
            err_nxt.len = 1'b1;
            state_nxt   = ST_HUNT;
          end else begin
            ld_len    = 1'b1;
            state_nxt = (rx_data == 8'h00) ? ST_CHK : ST_PLD;
          end
        end
      end
      ST_PLD: begin
        if (rx_ok) begin
          wr_pld = 1'b1;
          if (idx_q == (len_q - LEN_W'(1))) begin
            state_nxt = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (rx_ok) begin
          if (rx_data == chk_q) begin
            state_nxt = ST_HOLD;
          end else begin
            err_nxt.chk = 1'b1;
            state_nxt   = ST_HUNT;
          end
        end
      end
      ST_HOLD: begin
        // Bytes cannot be stored while a command is pending; they are dropped.
        if (rx_data_rdy) begin
          err_nxt.ovr = 1'b1;
        end
        if (cmd_ready) begin
          state_nxt = ST_HUNT;
        end
      end
      default: begin
        state_nxt = ST_HUNT;
      end
    endcase
    // Aborts common to every in-frame state; a byte in the expiry cycle wins.
    if (tmo_run) begin
      if (rx_data_rdy && frm_err) begin
        err_nxt   = ERR_NONE;
        err_nxt.frm = 1'b1;
        state_nxt = ST_HUNT;
      end else if (!rx_data_rdy && tmo_expired) begin
        err_nxt.tmo = 1'b1;
        state_nxt   = ST_HUNT;
      end
    end
  end

  // Command fields, running checksum, payload index and error pulse registers.
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      code_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      chk_q  <= '0;
      err_q  <= ERR_NONE;
    end else begin
      err_q <= err_nxt;
      if (ld_code) begin
        code_q <= rx_data;
        chk_q  <= rx_data;
      end
      if (ld_len) begin
        len_q <= LEN_W'(rx_data);
        idx_q <= '0;
        chk_q <= chk_q ^ rx_data;
      end
      if (wr_pld) begin
        idx_q <= idx_q + LEN_W'(1);
        chk_q <= chk_q ^ rx_data;
      end
    end
  end

  // Payload storage; contents survive reset and aborted frames.
  always_ff @(posedge clk_rx) begin
    if (!rst_clk_rx && wr_pld) begin
      pld_buf[idx_q[IDX_W-1:0]] <= rx_data;
    end
  end

  // Combinational payload read port, zero outside the buffer.
  always_comb begin
    pld_data = 8'h00;
    if (pld_addr < LEN_W'(MAX_LEN)) begin
      pld_data = pld_buf[pld_addr[IDX_W-1:0]];
    end
  end

  assign cmd_valid = (state == ST_HOLD);
  assign cmd_code  = code_q;
  assign cmd_len   = len_q;
  assign err_chk   = err_q.chk;
  assign err_len   = err_q.len;
  assign err_tmo   = err_q.tmo;
  assign err_frm   = err_q.frm;
  assign err_ovr   = err_q.ovr;

endmodule
